random_prog_loader: RTL and testbench
=====================================

// Module: random_prog_loader
// PURPOSE
// Upstream feeder for the CNv4 random-math executor. Accepts a per-height random program as a
// stream of 56-bit instruction words and validates each word. Writes valid words into the
// executor's instruction RAM, then launches the executor with a one-cycle start pulse and
// waits for its ack. Reports length, done, run count and error status to the control block.
// PARAMETERS
// ADDR_W        8  instruction RAM address width
// DEPTH       256  max program length in words, RET included (<= 2**ADDR_W)
// NUM_REGS      9  valid register index range 0..NUM_REGS-1
// OP_RET        6  RET opcode; valid opcodes are 0..OP_RET
// TIMEOUT_SLACK 8  cycles allowed beyond prog_len for the executor to ack
// PORTS
// clk              in   1       clock
// reset_n          in   1       synchronous active-low reset
// prog_valid       in   1       instruction word valid
// prog_ready       out  1       loader accepts a word (beat = prog_valid & prog_ready)
// prog_data        in   56      {opcode[55:48], dst[47:40], src[39:32], imm[31:0]}
// prog_last        in   1       final word of program; must coincide with opcode==OP_RET
// flush            in   1       discard program and clear error; return to LOAD
// run              in   1       request one execution of the armed program
// random_ram_we    out  1       RAM write strobe
// random_ram_waddr out  ADDR_W  RAM write address
// random_ram_wdata out  56      RAM write data
// math_start       out  1       one-cycle executor start pulse
// math_ack         in   1       executor completion pulse
// prog_len         out  ADDR_W+1 words in the armed program, RET included
// armed            out  1       high in ARMED
// busy             out  1       high in RUN
// done             out  1       one-cycle pulse on accepted math_ack
// err              out  1       high in ERR
// err_code         out  3       1 bad opcode, 2 bad index, 3 last/RET mismatch, 4 overflow, 5 timeout
// run_cnt          out  16      completed executions since last flush; wraps at 0xFFFF->0
// BEHAVIOUR
// - Reset (reset_n low at posedge): state LOAD, word count 0. All outputs 0 except prog_ready=1.
// - Reset mid-RUN abandons the execution silently; no math_start is reissued.
// - States LOAD, ARMED, RUN, ERR. prog_ready = (state==LOAD); no word is accepted elsewhere.
// - LOAD, each beat: register one cycle, then random_ram_we=1, waddr=count, wdata=prog_data.
//   count increments after each beat.
// - Beat checks, in priority order; the first hit wins:
//   opcode>OP_RET -> code 1.
//   opcode!=OP_RET and (dst>=NUM_REGS or src>=NUM_REGS) -> code 2; a RET word's indices are ignored.
//   (opcode==OP_RET) != prog_last -> code 3.
//   count==DEPTH-1 and opcode!=OP_RET -> code 4.
// - Any hit: next state ERR, err_code latched, and the failing word is NOT written.
// - Good beat with RET+last: word written, prog_len<=count+1, next state ARMED.
// - ARMED: run -> math_start=1 for exactly the next cycle; state RUN; timeout counter cleared.
//   flush in the same cycle as run wins: no start is issued.
// - RUN: the timeout counter increments each cycle.
//   math_ack -> done pulse next cycle, run_cnt+1, back to ARMED. The program is reusable.
//   Counter > prog_len+TIMEOUT_SLACK with no ack -> ERR, code 5.
//   If ack and timeout occur in the same cycle, ack wins.
// - math_ack outside RUN is ignored. run outside ARMED is ignored.
// - flush in LOAD/ARMED/ERR: next state LOAD; count, prog_len, err_code and run_cnt are cleared.
//   RAM contents are not cleared. flush is ignored in RUN.
// - ERR holds until flush or reset. err and err_code are stable in ERR.
// TESTING
// - 3-word program (ADD r1,r2,imm=0x10; XOR r0,r3; RET+last) -> 3 RAM writes at addr 0,1,2
//   with matching data; armed=1; prog_len=3.
// - Armed, run pulse, ack 5 cycles after start -> one math_start pulse, busy 5 cycles,
//   done pulse, run_cnt=1. Second run -> run_cnt=2.
// - Word with opcode=7 at index 1 -> err=1, err_code=1, no write at addr 1.
//   flush -> LOAD, err=0, prog_ready=1.
// - MUL dst=9 -> code 2. prog_last on SUB -> code 3. RET without last -> code 3.
// - 256 non-RET words (DEPTH=256) -> 255 writes, last word rejected, code 4.
// - prog_len=3, no ack -> err_code=5 exactly 3+8+1 cycles after start. run+flush together
//   in ARMED -> LOAD, no start.

Source files
------------

// File: rtl/random_prog_loader_if.sv
// Instruction-word stream between the program source and the loader.
interface random_prog_loader_if;
  logic        prog_valid;
  logic        prog_ready;
  logic [55:0] prog_data;
  logic        prog_last;

  modport master (output prog_valid, output prog_data, output prog_last, input prog_ready);
  modport slave  (input prog_valid, input prog_data, input prog_last, output prog_ready);
endinterface

// File: rtl/random_prog_loader.sv
// Loads, validates and launches a per-height random program for the CNv4
// random-math executor; tracks run count, timeout and error status.
module random_prog_loader #(
  parameter int ADDR_W        = 8,
  parameter int DEPTH         = 256,
  parameter int NUM_REGS      = 9,
  parameter int OP_RET        = 6,
  parameter int TIMEOUT_SLACK = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  random_prog_loader_if.slave       prog,
  input  logic                      flush,
  input  logic                      run,
  output logic                      random_ram_we,
  output logic [ADDR_W-1:0]         random_ram_waddr,
  output logic [55:0]               random_ram_wdata,
  output logic                      math_start,
  input  logic                      math_ack,
  output logic [ADDR_W:0]           prog_len,
  output logic                      armed,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [2:0]                err_code,
  output logic [15:0]               run_cnt
);

  localparam int TW = $clog2(DEPTH + TIMEOUT_SLACK + 2) + 1;
  localparam logic [7:0] OP_RET_B = 8'(OP_RET);
  localparam logic [7:0] NREG_B   = 8'(NUM_REGS);

  typedef enum logic [1:0] {S_LOAD, S_ARMED, S_RUN, S_ERR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic [TW-1:0]     tcnt;
  logic [TW-1:0]     tcnt_next;
  logic [TW-1:0]     limit;
  logic [7:0]        opcode;
  logic [7:0]        dst;
  logic [7:0]        src;
  logic              is_ret;
  logic              beat;
  logic [2:0]        beat_code;

  assign opcode    = prog.prog_data[55:48];
  assign dst       = prog.prog_data[47:40];
  assign src       = prog.prog_data[39:32];
  assign is_ret    = (opcode == OP_RET_B);
  assign beat      = prog.prog_valid && (state == S_LOAD);
  assign tcnt_next = tcnt + 1'b1;
  assign limit     = TW'(prog_len) + TW'(TIMEOUT_SLACK);

  assign prog.prog_ready = (state == S_LOAD);
  assign armed           = (state == S_ARMED);
  assign busy            = (state == S_RUN);
  assign err             = (state == S_ERR);

  // Prioritised validation of the incoming word; first failing rule wins
  always_comb begin
    beat_code = 3'd0;
    if (opcode > OP_RET_B)
      beat_code = 3'd1;
    else if (!is_ret && (dst >= NREG_B || src >= NREG_B))
      beat_code = 3'd2;
    else if (is_ret != prog.prog_last)
      beat_code = 3'd3;
    else if (count == ADDR_W'(DEPTH - 1) && !is_ret)
      beat_code = 3'd4;
  end

  // Control FSM with registered RAM-write, start and done strobes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= S_LOAD;
      count            <= '0;
      prog_len         <= '0;
      err_code         <= '0;
      run_cnt          <= '0;
      tcnt             <= '0;
      random_ram_we    <= 1'b0;
      random_ram_waddr <= '0;
      random_ram_wdata <= '0;
      math_start       <= 1'b0;
      done             <= 1'b0;
    end else begin
      random_ram_we <= 1'b0;
      math_start    <= 1'b0;
      done          <= 1'b0;
      unique case (state)
        S_LOAD: begin
          if (flush) begin
            count    <= '0;
            prog_len <= '0;
            err_code <= '0;
            run_cnt  <= '0;
          end else if (beat) begin
            if (beat_code != 3'd0) begin
              state    <= S_ERR;
              err_code <= beat_code;
            end else begin
              random_ram_we    <= 1'b1;
              random_ram_waddr <= count;
              random_ram_wdata <= prog.prog_data;
              count            <= count + 1'b1;
              if (is_ret) begin
                prog_len <= (ADDR_W + 1)'(count) + 1'b1;
                state    <= S_ARMED;
              end
            end
          end
        end
        S_ARMED: begin
          if (flush) begin
            state    <= S_LOAD;
            count    <= '0;
            prog_len <= '0;
            err_code <= '0;
            run_cnt  <= '0;
          end else if (run) begin
            math_start <= 1'b1;
            tcnt       <= '0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          // Timeout compares the post-increment count so the error lands
          // prog_len+TIMEOUT_SLACK+1 cycles after the start pulse.
          tcnt <= tcnt_next;
          if (math_ack) begin
            done    <= 1'b1;
            run_cnt <= run_cnt + 16'd1;
            state   <= S_ARMED;
          end else if (tcnt_next > limit) begin
            err_code <= 3'd5;
            state    <= S_ERR;
          end
        end
        S_ERR: begin
          if (flush) begin
            state    <= S_LOAD;
            count    <= '0;
            prog_len <= '0;
            err_code <= '0;
            run_cnt  <= '0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_random_prog_loader.sv
// Directed bench for random_prog_loader with a RAM-write scoreboard.
module tb_random_prog_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        run;
  logic        math_ack;
  logic        random_ram_we;
  logic [7:0]  random_ram_waddr;
  logic [55:0] random_ram_wdata;
  logic        math_start;
  logic [8:0]  prog_len;
  logic        armed;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] run_cnt;

  random_prog_loader_if pif ();

  random_prog_loader #(
    .ADDR_W        (8),
    .DEPTH         (256),
    .NUM_REGS      (9),
    .OP_RET        (6),
    .TIMEOUT_SLACK (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .prog             (pif),
    .flush            (flush),
    .run              (run),
    .random_ram_we    (random_ram_we),
    .random_ram_waddr (random_ram_waddr),
    .random_ram_wdata (random_ram_wdata),
    .math_start       (math_start),
    .math_ack         (math_ack),
    .prog_len         (prog_len),
    .armed            (armed),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .err_code         (err_code),
    .run_cnt          (run_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [55:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned start_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned busy_cyc = 0;
  logic [7:0]  exp_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every RAM write must match the oldest expected write
  always @(negedge clk) begin
    if (reset_n === 1'b1 && random_ram_we === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL wr_unexpected observed addr=%0h expected no write", random_ram_waddr);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(random_ram_waddr), 64'(e.addr));
        chk("wr_data", 64'(random_ram_wdata), 64'(e.data));
      end
    end
    if (math_start === 1'b1) start_cnt++;
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] op, input logic [7:0] d, input logic [7:0] s,
                      input logic [31:0] imm, input logic last, input logic wr);
    logic [55:0] w;
    w = {op, d, s, imm};
    pif.prog_valid = 1'b1;
    pif.prog_data  = w;
    pif.prog_last  = last;
    if (wr) begin
      exp_q.push_back({exp_cnt, w});
      exp_cnt++;
    end
    step();
    pif.prog_valid = 1'b0;
    pif.prog_last  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0;
    int unsigned b0;
    reset_n        = 1'b0;
    flush          = 1'b0;
    run            = 1'b0;
    math_ack       = 1'b0;
    pif.prog_valid = 1'b0;
    pif.prog_data  = '0;
    pif.prog_last  = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_ready", pif.prog_ready, 1);
    chk("rst_armed", armed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_runcnt", run_cnt, 0);
    chk("rst_len", prog_len, 0);
    chk("rst_start", math_start, 0);
    chk("rst_we", random_ram_we, 0);
    reset_n = 1'b1;
    step();

    // 3-word program: ADD r1,r2,0x10; XOR r0,r3; RET+last
    send(8'd0, 8'd1, 8'd2, 32'h10, 1'b0, 1'b1);
    send(8'd3, 8'd0, 8'd3, 32'h0, 1'b0, 1'b1);
    send(8'd6, 8'd0, 8'd0, 32'h0, 1'b1, 1'b1);
    chk("load_armed", armed, 1);
    chk("load_len", prog_len, 3);
    chk("load_ready", pif.prog_ready, 0);
    step();
    chk("load_drained", exp_q.size(), 0);

    // First run, ack sampled five cycles after the start edge
    s0 = start_cnt;
    b0 = busy_cyc;
    run = 1'b1;
    step();
    run = 1'b0;
    chk("run1_start", math_start, 1);
    chk("run1_busy", busy, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("run1_start_once", math_start, 0);
      chk("run1_busy_hold", busy, 1);
    end
    math_ack = 1'b1;
    step();
    math_ack = 1'b0;
    chk("run1_done", done, 1);
    chk("run1_cnt", run_cnt, 1);
    chk("run1_armed", armed, 1);
    step();
    chk("run1_done_pulse", done, 0);
    chk("run1_starts", start_cnt - s0, 1);
    chk("run1_busy_cycles", busy_cyc - b0, 5);

    // Second run reuses the program
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    math_ack = 1'b1;
    step();
    math_ack = 1'b0;
    chk("run2_done", done, 1);
    chk("run2_cnt", run_cnt, 2);
    chk("run2_starts", start_cnt - s0, 2);

    // Ack outside RUN is ignored
    step();
    math_ack = 1'b1;
    step();
    math_ack = 1'b0;
    step();
    chk("stray_ack_cnt", run_cnt, 2);
    chk("stray_ack_done", done_cnt, 2);

    // Timeout: no ack, error exactly prog_len+8+1 cycles after start
    run = 1'b1;
    step();
    run = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("timeout_err", err, (i == 12) ? 1 : 0);
    end
    chk("timeout_code", err_code, 5);
    chk("timeout_busy", busy, 0);
    step();
    chk("timeout_code_stable", err_code, 5);
    do_flush();
    chk("flush_ready", pif.prog_ready, 1);
    chk("flush_err", err, 0);
    chk("flush_code", err_code, 0);
    chk("flush_runcnt", run_cnt, 0);
    chk("flush_len", prog_len, 0);

    // Bad opcode at index 1
    send(8'd0, 8'd1, 8'd1, 32'h5, 1'b0, 1'b1);
    send(8'd7, 8'd0, 8'd0, 32'h0, 1'b0, 1'b0);
    chk("badop_err", err, 1);
    chk("badop_code", err_code, 1);
    chk("badop_ready", pif.prog_ready, 0);
    step();
    step();
    chk("badop_code_stable", err_code, 1);
    do_flush();
    chk("badop_flush_ready", pif.prog_ready, 1);
    chk("badop_flush_err", err, 0);

    // Bad register index
    send(8'd2, 8'd9, 8'd0, 32'h0, 1'b0, 1'b0);
    chk("badidx_code", err_code, 2);
    do_flush();

    // prog_last on a non-RET word
    send(8'd1, 8'd1, 8'd1, 32'h0, 1'b1, 1'b0);
    chk("lastsub_code", err_code, 3);
    do_flush();

    // RET without prog_last
    send(8'd6, 8'd0, 8'd0, 32'h0, 1'b0, 1'b0);
    chk("retnolast_code", err_code, 3);
    do_flush();

    // RET with out-of-range indices is still accepted
    send(8'd6, 8'd15, 8'd15, 32'hABCD, 1'b1, 1'b1);
    chk("retidx_armed", armed, 1);
    chk("retidx_len", prog_len, 1);
    step();
    do_flush();

    // Overflow: 256 non-RET words, only 255 written
    for (int i = 0; i < 256; i++) begin
      send(8'(i % 6), 8'(i % 9), 8'((i + 3) % 9), 32'(i * 32'h1001), 1'b0, (i < 255) ? 1'b1 : 1'b0);
    end
    chk("ovf_err", err, 1);
    chk("ovf_code", err_code, 4);
    step();
    step();
    chk("ovf_drained", exp_q.size(), 0);
    do_flush();

    // run and flush together in ARMED: flush wins, no start
    send(8'd6, 8'd0, 8'd0, 32'h0, 1'b1, 1'b1);
    s0 = start_cnt;
    run   = 1'b1;
    flush = 1'b1;
    step();
    run   = 1'b0;
    flush = 1'b0;
    exp_cnt = '0;
    chk("runflush_start", math_start, 0);
    chk("runflush_ready", pif.prog_ready, 1);
    chk("runflush_armed", armed, 0);
    step();
    chk("runflush_nostart", start_cnt - s0, 0);

    // Reset during RUN abandons the execution
    send(8'd6, 8'd0, 8'd0, 32'h0, 1'b1, 1'b1);
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    s0 = start_cnt;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_cnt = '0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", pif.prog_ready, 1);
    chk("midrst_len", prog_len, 0);
    repeat (3) step();
    chk("midrst_nostart", start_cnt - s0, 0);
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
